// File: rtl/call_request_unit.sv
// Elevator call front end: synchronises and debounces the buttons, latches pending
// hall/car calls, drives the request LEDs and registers the next target floor.
module call_request_unit #(
  parameter int DB_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       floor_0_p,
  input  logic       floor_1_p,
  input  logic       floor_2_p,
  input  logic       floor_3_p,
  input  logic       floor_4_p,
  input  logic       direction_1,
  input  logic       direction_2,
  input  logic       direction_3,
  input  logic       floor_0_d,
  input  logic       floor_1_d,
  input  logic       floor_2_d,
  input  logic       floor_3_d,
  input  logic       floor_4_d,
  input  logic [2:0] cur_floor,
  input  logic       dir_up,
  input  logic       serve_valid,
  input  logic [2:0] serve_floor,
  input  logic       serve_dir,
  output logic       led_inside_0,
  output logic       led_inside_1,
  output logic       led_inside_2,
  output logic       led_inside_3,
  output logic       led_inside_4,
  output logic       led_outside_0,
  output logic       led_outside_1,
  output logic       led_outside_2,
  output logic       led_outside_3,
  output logic       led_outside_4,
  output logic [2:0] target_floor,
  output logic       target_valid
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  // Bits 4:0 hall buttons, 9:5 car buttons, 12:10 hall direction for floors 1-3.
  logic [12:0] raw;
  logic [12:0] sync_a;
  logic [12:0] sync_b;

  assign raw = {direction_3, direction_2, direction_1,
                floor_4_d, floor_3_d, floor_2_d, floor_1_d, floor_0_d,
                floor_4_p, floor_3_p, floor_2_p, floor_1_p, floor_0_p};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  logic [9:0]    deb;
  logic [9:0]    deb_q;
  logic [CW-1:0] cnt [10];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 10; i++) cnt[i] <= '0;
    end else begin
      deb_q <= deb;
      for (int i = 0; i < 10; i++) begin
        if (sync_b[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync_b[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  logic [9:0] press;
  logic [2:0] dir_sync;
  logic [4:0] hit;
  logic [3:0] hall_up, set_up, clr_up;
  logic [4:1] hall_dn, set_dn, clr_dn;
  logic [4:0] car;
  logic [4:0] req;

  assign press    = deb & ~deb_q;
  assign dir_sync = sync_b[12:10];

  always_comb begin
    hit = '0;
    for (int f = 0; f < 5; f++) hit[f] = serve_valid && (serve_floor == 3'(f));
  end

  // End floors only have one hall direction, so they ignore the button and serve direction.
  assign set_up = {press[3:1] & dir_sync, press[0]};
  assign set_dn = {press[4], press[3:1] & ~dir_sync};
  assign clr_up = {hit[3:1] & {3{serve_dir}}, hit[0]};
  assign clr_dn = {hit[4], hit[3:1] & {3{~serve_dir}}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hall_up <= '0;
      hall_dn <= '0;
      car     <= '0;
    end else begin
      hall_up <= set_up | (hall_up & ~clr_up);
      hall_dn <= set_dn | (hall_dn & ~clr_dn);
      car     <= press[9:5] | (car & ~hit);
    end
  end

  assign req = car | {1'b0, hall_up} | {hall_dn, 1'b0};

  logic [2:0] sel, above, below;
  logic       here, above_found, below_found, sel_valid;

  // Nearest request above comes from the last hit of a downward scan, nearest below from an upward one.
  always_comb begin
    here        = 1'b0;
    above       = '0;
    below       = '0;
    above_found = 1'b0;
    below_found = 1'b0;
    sel         = cur_floor;
    for (int f = 4; f >= 0; f--) begin
      if (req[f] && (3'(f) > cur_floor)) begin
        above_found = 1'b1;
        above       = 3'(f);
      end
    end
    for (int f = 0; f < 5; f++) begin
      if (req[f] && (3'(f) < cur_floor)) begin
        below_found = 1'b1;
        below       = 3'(f);
      end
      if (req[f] && (3'(f) == cur_floor)) here = 1'b1;
    end
    if (here)
      sel = cur_floor;
    else if (dir_up ? above_found : below_found)
      sel = dir_up ? above : below;
    else
      sel = dir_up ? below : above;
    sel_valid = (|req) && (cur_floor <= 3'd4);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      target_floor <= '0;
      target_valid <= 1'b0;
    end else begin
      if (sel_valid) target_floor <= sel;
      target_valid <= sel_valid;
    end
  end

  assign led_inside_0  = car[0];
  assign led_inside_1  = car[1];
  assign led_inside_2  = car[2];
  assign led_inside_3  = car[3];
  assign led_inside_4  = car[4];
  assign led_outside_0 = hall_up[0];
  assign led_outside_1 = hall_up[1] | hall_dn[1];
  assign led_outside_2 = hall_up[2] | hall_dn[2];
  assign led_outside_3 = hall_up[3] | hall_dn[3];
  assign led_outside_4 = hall_dn[4];

endmodule

// File: tb/tb_call_request_unit.sv
// Directed bench for call_request_unit with DB_CYCLES = 4 and hand-computed expectations.
module tb_call_request_unit;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] hall_btn = '0;
  logic [4:0] car_btn = '0;
  logic [3:1] dir_btn = '0;
  logic [2:0] cur_floor = '0;
  logic       dir_up = 1'b1;
  logic       serve_valid = 1'b0;
  logic [2:0] serve_floor = '0;
  logic       serve_dir = 1'b0;
  logic [4:0] led_in;
  logic [4:0] led_out;
  logic [2:0] target_floor;
  logic       target_valid;

  int checks = 0;
  int errors = 0;

  call_request_unit #(.DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst),
    .floor_0_p(hall_btn[0]), .floor_1_p(hall_btn[1]), .floor_2_p(hall_btn[2]),
    .floor_3_p(hall_btn[3]), .floor_4_p(hall_btn[4]),
    .direction_1(dir_btn[1]), .direction_2(dir_btn[2]), .direction_3(dir_btn[3]),
    .floor_0_d(car_btn[0]), .floor_1_d(car_btn[1]), .floor_2_d(car_btn[2]),
    .floor_3_d(car_btn[3]), .floor_4_d(car_btn[4]),
    .cur_floor(cur_floor), .dir_up(dir_up),
    .serve_valid(serve_valid), .serve_floor(serve_floor), .serve_dir(serve_dir),
    .led_inside_0(led_in[0]), .led_inside_1(led_in[1]), .led_inside_2(led_in[2]),
    .led_inside_3(led_in[3]), .led_inside_4(led_in[4]),
    .led_outside_0(led_out[0]), .led_outside_1(led_out[1]), .led_outside_2(led_out[2]),
    .led_outside_3(led_out[3]), .led_outside_4(led_out[4]),
    .target_floor(target_floor), .target_valid(target_valid)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on falling edges only.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic serve(input logic [2:0] floor, input logic dir);
    serve_valid = 1'b1;
    serve_floor = floor;
    serve_dir   = dir;
    applyStimulus(1);
    serve_valid = 1'b0;
  endtask

  task automatic press_and_release(input logic [4:0] hall, input logic [4:0] cars);
    hall_btn = hall;
    car_btn  = cars;
    applyStimulus(8);
    hall_btn = '0;
    car_btn  = '0;
    applyStimulus(DB + 3);
  endtask

  task automatic do_reset();
    hall_btn = '0;
    car_btn  = '0;
    dir_btn  = '0;
    rst = 1'b0;
    applyStimulus(2);
    rst = 1'b1;
    applyStimulus(1);
  endtask

  initial begin
    // Reset with every button held
    hall_btn = 5'b11111;
    car_btn  = 5'b11111;
    applyStimulus(3);
    checkOutput("rst_led_in", 8'(led_in), 8'h00);
    checkOutput("rst_led_out", 8'(led_out), 8'h00);
    checkOutput("rst_tvalid", 8'(target_valid), 8'h00);
    checkOutput("rst_tfloor", 8'(target_floor), 8'h00);
    rst = 1'b1;
    applyStimulus(6);
    checkOutput("held_before_e6", 8'(led_in), 8'h00);
    applyStimulus(1);
    checkOutput("held_in_e6", 8'(led_in), 8'h1f);
    checkOutput("held_out_e6", 8'(led_out), 8'h1f);
    applyStimulus(1);
    checkOutput("held_tvalid", 8'(target_valid), 8'h01);
    checkOutput("held_tfloor", 8'(target_floor), 8'h00);
    do_reset();
    checkOutput("midrst_led_out", 8'(led_out), 8'h00);
    checkOutput("midrst_tvalid", 8'(target_valid), 8'h00);

    // Glitch rejection then a real press on floor 2 (direction low -> down call)
    hall_btn[2] = 1'b1;
    applyStimulus(3);
    hall_btn[2] = 1'b0;
    applyStimulus(10);
    checkOutput("glitch_led", 8'(led_out), 8'h00);
    checkOutput("glitch_tvalid", 8'(target_valid), 8'h00);
    hall_btn[2] = 1'b1;
    applyStimulus(6);
    checkOutput("press_before_e6", 8'(led_out), 8'h00);
    applyStimulus(1);
    checkOutput("press_led_e6", 8'(led_out), 8'h04);
    checkOutput("press_tvalid_e6", 8'(target_valid), 8'h00);
    applyStimulus(1);
    checkOutput("press_tfloor_e7", 8'(target_floor), 8'h02);
    checkOutput("press_tvalid_e7", 8'(target_valid), 8'h01);
    applyStimulus(3);
    hall_btn[2] = 1'b0;
    applyStimulus(8);
    checkOutput("release_no_event", 8'(led_out), 8'h04);
    serve(3'd2, 1'b0);
    checkOutput("serve_clear_led", 8'(led_out), 8'h00);
    checkOutput("serve_tvalid_n", 8'(target_valid), 8'h01);
    applyStimulus(1);
    checkOutput("serve_tvalid_n1", 8'(target_valid), 8'h00);
    checkOutput("serve_tfloor_hold", 8'(target_floor), 8'h02);

    // Direction latched at the press edge
    dir_btn[2] = 1'b1;
    applyStimulus(3);
    press_and_release(5'b00100, 5'b00000);
    checkOutput("dir_up_set", 8'(led_out), 8'h04);
    serve(3'd2, 1'b0);
    checkOutput("dir_wrong_serve", 8'(led_out), 8'h04);
    serve(3'd2, 1'b1);
    checkOutput("dir_right_serve", 8'(led_out), 8'h00);
    dir_btn[2] = 1'b0;
    applyStimulus(4);

    // Target selection
    cur_floor = 3'd2;
    dir_up    = 1'b1;
    press_and_release(5'b00000, 5'b10010);
    checkOutput("sel_led_in", 8'(led_in), 8'h12);
    checkOutput("sel_up", 8'(target_floor), 8'h04);
    dir_up = 1'b0;
    applyStimulus(1);
    checkOutput("sel_down", 8'(target_floor), 8'h01);
    press_and_release(5'b00000, 5'b00100);
    checkOutput("sel_here", 8'(target_floor), 8'h02);
    do_reset();
    checkOutput("sel_rst_led_in", 8'(led_in), 8'h00);

    // Press event and serve of floor 3 on the same edge: set wins
    cur_floor = 3'd0;
    dir_up    = 1'b1;
    car_btn[3] = 1'b1;
    applyStimulus(6);
    serve(3'd3, 1'b1);
    checkOutput("set_wins", 8'(led_in), 8'h08);
    serve(3'd3, 1'b0);
    checkOutput("held_serve_clear", 8'(led_in), 8'h00);
    applyStimulus(10);
    checkOutput("held_no_reset", 8'(led_in), 8'h00);
    car_btn[3] = 1'b0;
    applyStimulus(8);

    // Boundary floors and out-of-range values
    press_and_release(5'b10000, 5'b00000);
    checkOutput("top_hall_set", 8'(led_out), 8'h10);
    serve(3'd6, 1'b0);
    checkOutput("serve_floor6", 8'(led_out), 8'h10);
    checkOutput("top_target", 8'(target_floor), 8'h04);
    cur_floor = 3'd5;
    applyStimulus(1);
    checkOutput("cur5_tvalid", 8'(target_valid), 8'h00);
    checkOutput("cur5_tfloor", 8'(target_floor), 8'h04);
    cur_floor = 3'd0;
    serve(3'd4, 1'b1);
    checkOutput("top_clear_up", 8'(led_out), 8'h00);
    press_and_release(5'b00001, 5'b00000);
    checkOutput("bottom_hall_set", 8'(led_out), 8'h01);
    serve(3'd0, 1'b0);
    checkOutput("bottom_clear_dn", 8'(led_out), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
